// File: rtl/load_store_unit_pkg.sv
// Shared constants and store-lane helpers for the load/store unit.
// Optional build macro used by the top: LSU_MISALIGN_TRAP_EN.
package load_store_unit_pkg;

  localparam int unsigned WORD_LEN  = 32;
  localparam int unsigned ADDR_SIZE = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Unsupported funct3 codes fall through to a full-word access.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] strb;
    case (f3)
      F3_LB:   strb = 4'b0001 << lo;
      F3_LH:   strb = 4'b0011 << {lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [WORD_LEN-1:0] store_data(input logic [2:0] f3,
                                                     input logic [WORD_LEN-1:0] wd);
    logic [WORD_LEN-1:0] d;
    case (f3)
      F3_LB:   d = {4{wd[7:0]}};
      F3_LH:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic m;
    case (f3)
      F3_LB, F3_LBU: m = 1'b0;
      F3_LH, F3_LHU: m = lo[0];
      default:       m = (lo != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load extraction: picks the addressed byte/half from the bus word and extends it.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [WORD_LEN-1:0] bus_rdata,
  input  logic [1:0]          addr_lo,
  input  logic [2:0]          funct3,
  output logic [WORD_LEN-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = bus_rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3)
      F3_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ext_data = {24'd0, byte_sel};
      F3_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ext_data = {16'd0, half_sel};
      default: ext_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: req/ack bus handshake, core stall, store strobes and load extension.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses without a bus cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned STRB_W      = 4,
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_LEN-1:0]  wdata,
  output logic                 stall,
  output logic [WORD_LEN-1:0]  rdata,
  output logic                 fault,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [ADDR_SIZE-1:0] bus_addr,
  output logic [STRB_W-1:0]    bus_wstrb,
  output logic [WORD_LEN-1:0]  bus_wdata,
  input  logic                 bus_ack,
  input  logic [WORD_LEN-1:0]  bus_rdata
);

  logic [1:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [2:0]           f3_q, f3_d;
  logic [WORD_LEN-1:0]  wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic [WORD_LEN-1:0]  rdata_q, rdata_d;
  logic                 fault_q, fault_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [WORD_LEN-1:0]  ext_data;
  logic                 misaligned;

  lsu_load_align u_load_align (
    .bus_rdata (bus_rdata),
    .addr_lo   (addr_q[1:0]),
    .funct3    (f3_q),
    .ext_data  (ext_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(funct3, addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          stall   = 1'b1;
          addr_d  = addr;
          f3_d    = funct3;
          wdata_d = wdata;
          we_d    = mem_write;  // both lines high resolve to a store
          cnt_d   = '0;
          if (misaligned) begin
            state_d = ST_DONE;
            fault_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          if (!we_q) rdata_d = ext_data;
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == ACK_TIMEOUT - 1)) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;  // requests here belong to the committing instruction
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus_req   = (state_q == ST_REQ);
    bus_we    = bus_req && we_q;
    bus_addr  = {addr_q[ADDR_SIZE-1:2], 2'b00};
    bus_wstrb = bus_we ? STRB_W'(store_strb(f3_q, addr_q[1:0])) : '0;
    bus_wdata = store_data(f3_q, wdata_q);
    rdata     = rdata_q;
    fault     = fault_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit, built with a 4-cycle ack timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .STRB_W      (4),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .fault     (fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] brd;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  // observations from the last access
  logic        o_req_stall, o_we, o_done_stall, o_done_fault;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_strb;
  int          o_req_cnt, o_stall_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] brd, input int waits);
    o_req_cnt = 0; o_stall_cnt = 0;
    o_we = 1'b0; o_addr = '0; o_strb = '0; o_wdata = '0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    o_req_stall = stall;
    if (stall) o_stall_cnt++;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    while (bus_req && o_req_cnt < 64) begin
      if (o_req_cnt == 0) begin
        o_we = bus_we; o_addr = bus_addr; o_strb = bus_wstrb; o_wdata = bus_wdata;
      end
      if (stall) o_stall_cnt++;
      if (o_req_cnt == waits) begin
        bus_ack = 1'b1; bus_rdata = brd;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      o_req_cnt++;
    end
    o_done_stall = stall;
    o_done_fault = fault;
    @(posedge clk); #1;
  endtask

  logic [31:0] exp_rd;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1,
                 32'hDEADBEEF, 1'b0, 32'h10, 4'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'h80112233, 0,
                 32'hFFFFFF80, 1'b0, 32'h10, 4'h0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h80112233, 2,
                 32'h00000080, 1'b0, 32'h10, 4'h0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h80112233, 0,
                 32'hFFFF8011, 1'b0, 32'h10, 4'h0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h80112233, 0,
                 32'h00002233, 1'b0, 32'h10, 4'h0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 32'h80112233, 0,
                 32'h00000022, 1'b0, 32'h10, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h21, 32'hAB, 32'h0, 0,
                 32'h00000022, 1'b1, 32'h20, 4'b0010, 32'hABABABAB};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h22, 32'h1234, 32'h0, 1,
                 32'h00000022, 1'b1, 32'h20, 4'b1100, 32'h12341234};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 0,
                 32'h00000022, 1'b1, 32'h30, 4'b1111, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 1'b1, 3'b000, 32'h40, 32'h5A, 32'hFFFFFFFF, 0,
                 32'h00000022, 1'b1, 32'h40, 4'b0001, 32'h5A5A5A5A};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h44, 32'h0, 32'h01234567, 0,
                 32'h01234567, 1'b0, 32'h44, 4'h0, 32'h0};

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset bus_req", {31'd0, bus_req}, 32'd0);
    chk("reset bus_we", {31'd0, bus_we}, 32'd0);
    chk("reset bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("reset bus_addr", bus_addr, 32'd0);
    chk("reset bus_wdata", bus_wdata, 32'd0);
    chk("reset fault", {31'd0, fault}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd,
                 vecs[i].brd, vecs[i].waits);
      $display("vector %0d", i);
      chk("req-cycle stall", {31'd0, o_req_stall}, 32'd1);
      chk("req cycles", o_req_cnt, vecs[i].waits + 1);
      chk("stall cycles", o_stall_cnt, vecs[i].waits + 2);
      chk("done stall", {31'd0, o_done_stall}, 32'd0);
      chk("done fault", {31'd0, o_done_fault}, 32'd0);
      chk("bus_we", {31'd0, o_we}, {31'd0, vecs[i].exp_we});
      chk("bus_addr", o_addr, vecs[i].exp_addr);
      chk("bus_wstrb", {28'd0, o_strb}, {28'd0, vecs[i].exp_strb});
      if (vecs[i].exp_we) chk("bus_wdata", o_wdata, vecs[i].exp_wdata);
      chk("rdata", rdata, vecs[i].exp_rdata);
    end
    exp_rd = 32'h01234567;

    // Misaligned word access
`ifdef LSU_MISALIGN_TRAP_EN
    run_access(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 32'h11223344, 0);
    chk("misalign req cycles", o_req_cnt, 0);
    chk("misalign fault", {31'd0, o_done_fault}, 32'd1);
    chk("misalign rdata", rdata, exp_rd);
`else
    run_access(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 32'h11223344, 0);
    exp_rd = 32'h11223344;
    chk("unaligned word bus_addr", o_addr, 32'h0);
    chk("unaligned word fault", {31'd0, o_done_fault}, 32'd0);
    chk("unaligned word rdata", rdata, exp_rd);
`endif
    chk("fault cleared after done", {31'd0, fault}, 32'd0);

    // Timeout: never ack
    run_access(1'b1, 1'b0, 3'b010, 32'h60, 32'h0, 32'h0, -1);
    chk("timeout req cycles", o_req_cnt, 4);
    chk("timeout stall cycles", o_stall_cnt, 5);
    chk("timeout fault", {31'd0, o_done_fault}, 32'd1);
    chk("timeout rdata", rdata, exp_rd);
    chk("timeout fault one cycle", {31'd0, fault}, 32'd0);

    // Request held into DONE is not reissued
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h70;
    @(posedge clk); #1;
    mem_read = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    exp_rd = 32'hA5A5A5A5;
    chk("done stall", {31'd0, stall}, 32'd0);
    mem_read = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b0;
    #1;
    chk("done request ignored bus_req", {31'd0, bus_req}, 32'd0);
    chk("done request ignored stall", {31'd0, stall}, 32'd0);
    chk("rdata after done", rdata, exp_rd);

    // Reset in REQ, then a late ack
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h80;
    @(posedge clk); #1;
    mem_read = 1'b0;
    chk("pre-reset bus_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post-reset bus_req", {31'd0, bus_req}, 32'd0);
    chk("post-reset stall", {31'd0, stall}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("late ack rdata", rdata, 32'd0);
    chk("late ack bus_req", {31'd0, bus_req}, 32'd0);

    run_access(1'b1, 1'b0, 3'b101, 32'h92, 32'h0, 32'hBEEF0001, 0);
    chk("recovery rdata", rdata, 32'h0000BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
